turn_arbiter: RTL and testbench
===============================

Name: turn_arbiter

Overview:
Shares the game's player-load resource between two players once login access is granted. Sits downstream of the login/access FSM and drives the load strobes of the two player load registers. It enforces strict alternation (player 1 first), a per-turn timeout, and a fixed number of rounds before the game ends.

Parameters:
TIMEOUT, 8'd200, max cycles per turn before the turn is forfeited (legal range 2..255)
ROUNDS, 4'd5, number of full rounds (P1 turn + P2 turn) per game (legal range 1..15)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-low
access_ok  input  1  level; high while login is granted (driven from the access FSM's green/OK status)
req_1  input  1  1-cycle pulse, player 1 load request (from button shaper)
req_2  input  1  1-cycle pulse, player 2 load request
load_1  output  1  1-cycle strobe to player 1 load register
load_2  output  1  1-cycle strobe to player 2 load register
turn_1  output  1  level, player 1 turn LED
turn_2  output  1  level, player 2 turn LED
timeout  output  1  1-cycle pulse, a turn was forfeited
round_cnt  output  4  completed rounds
game_done  output  1  level, all rounds complete
state  output  2  current FSM state (debug/sim only, not wired to I/O)

Behaviour:
- Single clocked process, all outputs registered. RST==0 at a rising edge: state=IDLE; all outputs 0; timer=0; round_cnt=0. Reset mid-turn aborts the turn; no load strobe is issued.
- States: IDLE=2'b00, P1_TURN=2'b01, P2_TURN=2'b10, DONE=2'b11.
- IDLE: turn_1=turn_2=0, load_x=0. If access_ok==1, go to P1_TURN and set timer=0.
- P1_TURN: turn_1=1, turn_2=0. Each cycle:
  - If req_1==1: load_1=1 for the next cycle only; go to P2_TURN; timer=0.
  - Else if timer==TIMEOUT-1: timeout=1 for one cycle; go to P2_TURN; timer=0; no load.
  - Else timer+1.
  - req_2 in P1_TURN is ignored (out of turn).
- P2_TURN: mirror of P1_TURN with req_2/load_2/turn_2. On turn end (load or timeout):
  - round_cnt+1.
  - If the new round_cnt==ROUNDS, go to DONE; else go to P1_TURN with timer=0.
- DONE: game_done=1; turn_1=turn_2=0. Holds until RST; access_ok and req_x are ignored.
- Turn length: a turn lasts at most TIMEOUT cycles (timer 0..TIMEOUT-1). A request sampled in the expiry cycle wins: load is issued and timeout is not pulsed.
- Simultaneous req_1 and req_2: only the current player's request is honored. The other is dropped, not queued.
- access_ok==0 in P1_TURN/P2_TURN: next state is IDLE; round_cnt=0; timer=0; turn LEDs 0; no load or timeout pulse that cycle, even if a req arrives simultaneously (access loss has priority).
- load_x, timeout: exactly one cycle wide. Never asserted together. Never asserted in IDLE/DONE except the cycle immediately after the final P2 turn, where load_2 or timeout is visible together with game_done=1.
- Timer: 8-bit. It cannot exceed TIMEOUT-1 by construction.
- round_cnt: 4-bit. It increments only on a P2 turn end and never wraps within a game.

Test Plan:
- TIMEOUT=4, ROUNDS=2. Reset, then access_ok=1 -> IDLE→P1_TURN next cycle, turn_1=1. req_1 pulse -> load_1=1 for 1 cycle, turn_2=1, round_cnt=0.
- In P1_TURN, pulse req_2 only -> no load_2. After 4 cycles in the turn: timeout=1 for 1 cycle, turn moves to P2, load_1 never asserted.
- Simultaneous req_1 and req_2 in P1_TURN -> load_1=1, load_2=0. In P2_TURN, req_2 on the 4th cycle (timer=3) -> load_2=1, timeout=0, round_cnt=1.
- Complete two rounds -> round_cnt=2, game_done=1, turns 0. Subsequent req_1/req_2 and an access_ok toggle produce no outputs until RST.
- Drop access_ok mid P2_TURN with round_cnt=1 and req_2 in the same cycle -> IDLE, round_cnt=0, no load_2. Reassert access_ok -> P1_TURN.
- Assert RST low during P1_TURN with req_1 in the same cycle -> all outputs 0 and state=IDLE next cycle; no load_1 pulse.

Source files
------------

// File: rtl/turn_arbiter.sv
// Two-player turn arbiter: hands the shared load resource to player 1 and player 2
// in strict alternation once login access is granted, with a per-turn timeout and a fixed round count.
module turn_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd200,
    parameter logic [3:0] ROUNDS  = 4'd5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       access_ok,
    input  logic       req_1,
    input  logic       req_2,
    output logic       load_1,
    output logic       load_2,
    output logic       turn_1,
    output logic       turn_2,
    output logic       timeout,
    output logic [3:0] round_cnt,
    output logic       game_done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        P1_TURN = 2'b01,
        P2_TURN = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t     state_d,     state_q;
    logic [7:0] timer_d,     timer_q;
    logic [3:0] round_cnt_d, round_cnt_q;
    logic       load_1_d,    load_1_q;
    logic       load_2_d,    load_2_q;
    logic       turn_1_d,    turn_1_q;
    logic       turn_2_d,    turn_2_q;
    logic       timeout_d,   timeout_q;
    logic       game_done_d, game_done_q;

    logic       turn_expired_s;
    logic [3:0] round_inc_s;

    // Next-state and next-output logic; turn LEDs always track the state being entered.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        round_cnt_d    = round_cnt_q;
        load_1_d       = 1'b0;
        load_2_d       = 1'b0;
        turn_1_d       = 1'b0;
        turn_2_d       = 1'b0;
        timeout_d      = 1'b0;
        game_done_d    = game_done_q;
        turn_expired_s = (timer_q == (TIMEOUT - 8'd1));
        round_inc_s    = round_cnt_q + 4'd1;

        case (state_q)
            IDLE: begin
                game_done_d = 1'b0;
                if (access_ok) begin
                    state_d  = P1_TURN;
                    timer_d  = 8'd0;
                    turn_1_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end

            P1_TURN: begin
                // Losing access outranks any request arriving in the same cycle.
                if (!access_ok) begin
                    state_d     = IDLE;
                    timer_d     = 8'd0;
                    round_cnt_d = 4'd0;
                end else if (req_1) begin
                    load_1_d = 1'b1;
                    state_d  = P2_TURN;
                    timer_d  = 8'd0;
                    turn_2_d = 1'b1;
                end else if (turn_expired_s) begin
                    timeout_d = 1'b1;
                    state_d   = P2_TURN;
                    timer_d   = 8'd0;
                    turn_2_d  = 1'b1;
                end else begin
                    timer_d  = timer_q + 8'd1;
                    turn_1_d = 1'b1;
                end
            end

            P2_TURN: begin
                if (!access_ok) begin
                    state_d     = IDLE;
                    timer_d     = 8'd0;
                    round_cnt_d = 4'd0;
                end else if (req_2 || turn_expired_s) begin
                    load_2_d    = req_2;
                    timeout_d   = ~req_2;
                    timer_d     = 8'd0;
                    round_cnt_d = round_inc_s;
                    if (round_inc_s == ROUNDS) begin
                        state_d     = DONE;
                        game_done_d = 1'b1;
                    end else begin
                        state_d  = P1_TURN;
                        turn_1_d = 1'b1;
                    end
                end else begin
                    timer_d  = timer_q + 8'd1;
                    turn_2_d = 1'b1;
                end
            end

            DONE: begin
                state_d     = DONE;
                game_done_d = 1'b1;
            end

            default: begin
                state_d     = IDLE;
                timer_d     = 8'd0;
                round_cnt_d = 4'd0;
                game_done_d = 1'b0;
            end
        endcase
    end

    // State, timer and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            timer_q     <= 8'd0;
            round_cnt_q <= 4'd0;
            load_1_q    <= 1'b0;
            load_2_q    <= 1'b0;
            turn_1_q    <= 1'b0;
            turn_2_q    <= 1'b0;
            timeout_q   <= 1'b0;
            game_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            round_cnt_q <= round_cnt_d;
            load_1_q    <= load_1_d;
            load_2_q    <= load_2_d;
            turn_1_q    <= turn_1_d;
            turn_2_q    <= turn_2_d;
            timeout_q   <= timeout_d;
            game_done_q <= game_done_d;
        end
    end

    assign load_1    = load_1_q;
    assign load_2    = load_2_q;
    assign turn_1    = turn_1_q;
    assign turn_2    = turn_2_q;
    assign timeout   = timeout_q;
    assign round_cnt = round_cnt_q;
    assign game_done = game_done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed bench for turn_arbiter with TIMEOUT=4, ROUNDS=2; every output is compared
// after each clock edge against hand-computed expectations.
module tb_turn_arbiter;

    logic       CLK;
    logic       RST;
    logic       access_ok;
    logic       req_1;
    logic       req_2;
    logic       load_1;
    logic       load_2;
    logic       turn_1;
    logic       turn_2;
    logic       timeout;
    logic [3:0] round_cnt;
    logic       game_done;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    turn_arbiter #(
        .TIMEOUT(8'd4),
        .ROUNDS (4'd2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .access_ok(access_ok),
        .req_1    (req_1),
        .req_2    (req_2),
        .load_1   (load_1),
        .load_2   (load_2),
        .turn_1   (turn_1),
        .turn_2   (turn_2),
        .timeout  (timeout),
        .round_cnt(round_cnt),
        .game_done(game_done),
        .state    (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Compare the packed output vector {load_1,load_2,turn_1,turn_2,timeout,game_done,round_cnt,state}.
    task automatic expect_out(input string tag, input logic l1, input logic l2,
                              input logic t1, input logic t2, input logic to,
                              input logic gd, input logic [3:0] rc, input logic [1:0] st);
        logic [11:0] obs;
        logic [11:0] exp;
        obs = {load_1, load_2, turn_1, turn_2, timeout, game_done, round_cnt, state};
        exp = {l1, l2, t1, t2, to, gd, rc, st};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b0; access_ok = 1'b0; req_1 = 1'b0; req_2 = 1'b0;
        step(); step();
        expect_out("reset",           1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00);

        RST = 1'b1;
        step();
        expect_out("idle_no_access",  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00);

        access_ok = 1'b1;
        step();
        expect_out("enter_p1",        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,2'b01);

        req_1 = 1'b1;
        step();
        req_1 = 1'b0;
        expect_out("p1_load",         1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd0,2'b10);
        step();
        expect_out("load_one_cycle",  1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'd0,2'b10);
        step(); step();
        expect_out("p2_timer3",       1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'd0,2'b10);

        // Request in the expiry cycle wins over the timeout
        req_2 = 1'b1;
        step();
        req_2 = 1'b0;
        expect_out("p2_req_expiry",   1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4'd1,2'b01);

        req_2 = 1'b1;
        step();
        req_2 = 1'b0;
        expect_out("p1_ignore_req2",  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd1,2'b01);
        step(); step();
        expect_out("p1_pre_timeout",  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd1,2'b01);
        step();
        expect_out("p1_timeout",      1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,4'd1,2'b10);
        step();
        expect_out("timeout_1cycle",  1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'd1,2'b10);

        // Access loss mid P2 with a simultaneous request
        access_ok = 1'b0; req_2 = 1'b1;
        step();
        req_2 = 1'b0;
        expect_out("access_drop",     1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00);
        access_ok = 1'b1;
        step();
        expect_out("reaccess",        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,2'b01);

        req_1 = 1'b1; req_2 = 1'b1;
        step();
        req_1 = 1'b0; req_2 = 1'b0;
        expect_out("simul_req",       1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd0,2'b10);
        req_2 = 1'b1;
        step();
        req_2 = 1'b0;
        expect_out("p2_load",         1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4'd1,2'b01);

        req_1 = 1'b1;
        step();
        req_1 = 1'b0;
        expect_out("p1_load_r2",      1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd1,2'b10);
        step(); step(); step();
        step();
        expect_out("final_timeout",   1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'd2,2'b11);
        step();
        expect_out("done_hold",       1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd2,2'b11);

        req_1 = 1'b1; req_2 = 1'b1;
        step();
        req_1 = 1'b0; req_2 = 1'b0;
        expect_out("done_ignore_req", 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd2,2'b11);
        access_ok = 1'b0;
        step();
        access_ok = 1'b1;
        step();
        expect_out("done_ignore_acc", 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd2,2'b11);

        RST = 1'b0;
        step();
        expect_out("rst_from_done",   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00);
        RST = 1'b1;
        step();
        expect_out("restart_p1",      1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,2'b01);

        // Reset wins over a request in the same cycle
        RST = 1'b0; req_1 = 1'b1;
        step();
        RST = 1'b1; req_1 = 1'b0; access_ok = 1'b0;
        expect_out("rst_mid_turn",    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00);
        step();
        expect_out("no_late_load",    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
